// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port.
// Data has fixed priority; a 4-bit wait counter times out stuck accesses.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        bus_err
);

    localparam int unsigned     CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [2:0]      FETCH_F3 = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             busy_c;
    logic             done_c;
    logic [31:0]      rsp_word_c;

    // Grants and stall are combinational so a request is accepted in its own cycle;
    // they are gated by rst_n so every output reads 0 while reset is held.
    assign busy_c     = (state != IDLE);
    assign d_gnt      = rst_n & ~busy_c & d_req;
    assign if_gnt     = rst_n & ~busy_c & if_req & ~d_req;
    assign stall      = rst_n & (busy_c | d_req | if_req);
    assign mem_req    = busy_c;
    assign done_c     = mem_ready | (wait_cnt == CNT_LAST);
    assign rsp_word_c = (mem_ready & ~mem_we) ? mem_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            mem_we     <= 1'b0;
            mem_funct3 <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_valid   <= 1'b0;
            if_rdata   <= '0;
            d_valid    <= 1'b0;
            d_rdata    <= '0;
            bus_err    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (d_req) begin
                        state      <= BUSY_D;
                        mem_we     <= d_we;
                        mem_funct3 <= d_funct3;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                    end else if (if_req) begin
                        state      <= BUSY_I;
                        mem_we     <= 1'b0;
                        mem_funct3 <= FETCH_F3;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Completion or timeout; a ready on the terminal cycle wins over the timeout.
                    if (done_c) begin
                        state      <= IDLE;
                        wait_cnt   <= '0;
                        mem_we     <= 1'b0;
                        mem_funct3 <= '0;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                        bus_err    <= ~mem_ready;
                        if (state == BUSY_I) begin
                            if_valid <= 1'b1;
                            if_rdata <= rsp_word_c;
                        end else begin
                            d_valid  <= 1'b1;
                            d_rdata  <= rsp_word_c;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected memory requests and responses
// are queued by the stimulus and consumed by a monitor on the falling edge.
module tb_mem_port_arbiter;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_valid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_funct3 = 3'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt, d_valid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata;
    logic        stall, bus_err;

    logic [31:0] rdata_cfg = 32'h0;
    int          ready_at = 0;
    logic        force_ready = 1'b0;
    int          rcnt = 0;

    resp_t resp_q[$];
    mreq_t mem_q[$];
    int    err_cnt = 0;
    int    chk_cnt = 0;

    assign mem_rdata = rdata_cfg;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .stall(stall), .bus_err(bus_err)
    );

    // Memory model: asserts ready on the ready_at-th cycle of mem_req (0 = never).
    always @(negedge clk) begin
        if (mem_req) rcnt = rcnt + 1;
        else         rcnt = 0;
        mem_ready = force_ready | (mem_req && ready_at != 0 && rcnt == ready_at);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_resp(input logic is_d, input logic [31:0] rdata, input logic err);
        resp_t r;
        r.is_d = is_d; r.rdata = rdata; r.err = err;
        resp_q.push_back(r);
    endtask

    task automatic push_mem(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int len);
        mreq_t m;
        m.we = we; m.f3 = f3; m.addr = addr; m.wdata = wdata; m.len = len;
        mem_q.push_back(m);
    endtask

    // Holds a request until its grant is seen, then drops it after the grant edge.
    task automatic hold_gnt(input logic is_d);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (is_d ? d_gnt : if_gnt) begin
                @(posedge clk);
                #1;
                if (is_d) d_req = 1'b0;
                else      if_req = 1'b0;
                return;
            end
        end
        chk_cnt++;
        err_cnt++;
        $display("FAIL grant_timeout: no grant for is_d=%0d", is_d);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!stall && !mem_req && resp_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk_cnt++;
        err_cnt++;
        $display("FAIL idle_timeout: stall=%0d mem_req=%0d pending=%0d", stall, mem_req, resp_q.size());
    endtask

    task automatic monitor();
        resp_t r;
        mreq_t cur;
        int    mlen = 0;
        cur.len = 0;
        forever begin
            @(negedge clk);
            if (if_valid || d_valid || bus_err) begin
                if (resp_q.size() == 0) begin
                    chk_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_resp: if_valid=%0d d_valid=%0d bus_err=%0d at %0t",
                             if_valid, d_valid, bus_err, $time);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_port", {30'b0, if_valid, d_valid}, r.is_d ? 32'd1 : 32'd2);
                    check("resp_rdata", d_valid ? d_rdata : if_rdata, r.rdata);
                    check("resp_bus_err", 32'(bus_err), 32'(r.err));
                end
            end
            if (mem_req) begin
                if (mlen == 0) begin
                    if (mem_q.size() == 0) begin
                        chk_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_mem_req: addr=0x%08h", mem_addr);
                        cur.we = mem_we; cur.f3 = mem_funct3; cur.addr = mem_addr;
                        cur.wdata = mem_wdata; cur.len = 0;
                    end else begin
                        cur = mem_q.pop_front();
                        check("mem_we", 32'(mem_we), 32'(cur.we));
                        check("mem_funct3", 32'(mem_funct3), 32'(cur.f3));
                    end
                end
                check("mem_addr", mem_addr, cur.addr);
                check("mem_wdata", mem_wdata, cur.wdata);
                mlen++;
            end else begin
                if (mlen != 0) begin
                    check("mem_req_len", 32'(mlen), 32'(cur.len));
                    mlen = 0;
                end
                check("mem_idle_fields", mem_addr | mem_wdata | {28'b0, mem_we, mem_funct3}, 32'h0);
            end
        end
    endtask

    task automatic run_seq();
        // Reset state with both requests asserted.
        if_req = 1'b1; d_req = 1'b1;
        #12;
        check("rst_gnt", {30'b0, if_gnt, d_gnt}, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_valid", {29'b0, if_valid, d_valid, bus_err}, 32'h0);
        check("rst_rdata", if_rdata | d_rdata, 32'h0);
        if_req = 1'b0; d_req = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // V1: single fetch, minimum latency.
        if_addr = 32'h100; if_req = 1'b1; ready_at = 1; rdata_cfg = 32'h00500093;
        push_mem(1'b0, 3'b010, 32'h100, 32'h0, 1);
        push_resp(1'b0, 32'h00500093, 1'b0);
        hold_gnt(1'b0);
        @(negedge clk);
        check("v1_mem_req", 32'(mem_req), 32'h1);
        check("v1_mem_addr", mem_addr, 32'h100);
        check("v1_mem_f3", 32'(mem_funct3), 32'h2);
        @(negedge clk);
        check("v1_if_valid", 32'(if_valid), 32'h1);
        check("v1_if_rdata", if_rdata, 32'h00500093);
        wait_idle();

        // V2: simultaneous requests; store wins, fetch follows back-to-back.
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h104; ready_at = 1; rdata_cfg = 32'h22222222;
        push_mem(1'b1, 3'b010, 32'h2000, 32'hDEADBEEF, 1);
        push_mem(1'b0, 3'b010, 32'h104, 32'h0, 1);
        push_resp(1'b1, 32'h0, 1'b0);
        push_resp(1'b0, 32'h22222222, 1'b0);
        hold_gnt(1'b1);
        @(negedge clk);
        check("v2_if_gnt_busy", 32'(if_gnt), 32'h0);
        check("v2_mem_we", 32'(mem_we), 32'h1);
        @(negedge clk);
        check("v2_if_gnt_after", {30'b0, d_valid, if_gnt}, 32'h3);
        @(posedge clk); #1;
        if_req = 1'b0; d_we = 1'b0;
        wait_idle();

        // V3: load never answered -> timeout after 15 mem_req cycles.
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b100; d_addr = 32'h3000; d_wdata = 32'h0;
        ready_at = 0; rdata_cfg = 32'hAAAAAAAA;
        push_mem(1'b0, 3'b100, 32'h3000, 32'h0, 15);
        push_resp(1'b1, 32'h0, 1'b1);
        hold_gnt(1'b1);
        wait_idle();

        // V4: ready on the terminal wait cycle completes normally.
        d_req = 1'b1; d_funct3 = 3'b010; d_addr = 32'h3004;
        ready_at = 15; rdata_cfg = 32'h12345678;
        push_mem(1'b0, 3'b010, 32'h3004, 32'h0, 15);
        push_resp(1'b1, 32'h12345678, 1'b0);
        hold_gnt(1'b1);
        wait_idle();

        // Fetch in between; d_rdata must hold the last data completion.
        if_req = 1'b1; if_addr = 32'h108; ready_at = 2; rdata_cfg = 32'h0BADF00D;
        push_mem(1'b0, 3'b010, 32'h108, 32'h0, 2);
        push_resp(1'b0, 32'h0BADF00D, 1'b0);
        hold_gnt(1'b0);
        wait_idle();
        check("hold_d_rdata", d_rdata, 32'h12345678);
        check("hold_if_rdata", if_rdata, 32'h0BADF00D);

        // mem_ready in IDLE has no effect.
        force_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_ready_valid", {30'b0, if_valid, d_valid}, 32'h0);
        check("idle_ready_mem_req", 32'(mem_req), 32'h0);
        force_ready = 1'b0;
        @(posedge clk); #1;

        // V5: reset during BUSY_D aborts silently; a later fetch is served.
        d_req = 1'b1; d_addr = 32'h4000; ready_at = 0;
        push_mem(1'b0, 3'b010, 32'h4000, 32'h0, 3);
        hold_gnt(1'b1);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("v5_mem_req", 32'(mem_req), 32'h0);
        check("v5_stall", 32'(stall), 32'h0);
        check("v5_gnt", {30'b0, if_gnt, d_gnt}, 32'h0);
        ready_at = 1; rdata_cfg = 32'h00000013;
        push_mem(1'b0, 3'b010, 32'h200, 32'h0, 1);
        push_resp(1'b0, 32'h00000013, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        hold_gnt(1'b0);
        wait_idle();

        // V6: data request during BUSY_I waits; granted on the if_valid cycle.
        if_req = 1'b1; if_addr = 32'h300; ready_at = 3; rdata_cfg = 32'h33333333;
        push_mem(1'b0, 3'b010, 32'h300, 32'h0, 3);
        push_mem(1'b1, 3'b001, 32'h5000, 32'h55AA55AA, 3);
        push_resp(1'b0, 32'h33333333, 1'b0);
        push_resp(1'b1, 32'h0, 1'b0);
        hold_gnt(1'b0);
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b001; d_addr = 32'h5000; d_wdata = 32'h55AA55AA;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("v6_stall", 32'(stall), 32'h1);
            if (d_gnt) begin
                check("v6_gnt_on_valid", 32'(if_valid), 32'h1);
                break;
            end
            if (n == 19) check("v6_d_gnt_timeout", 32'(d_gnt), 32'h1);
        end
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        check("resp_q_empty", 32'(resp_q.size()), 32'h0);
        check("mem_q_empty", 32'(mem_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    endtask

    initial begin
        fork
            monitor();
            run_seq();
        join
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: bench did not finish");
        $display("Result: errors=%0d of %0d checks", err_cnt + 1, chk_cnt + 1);
        $fatal(1, "timeout");
    end

endmodule
